// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline-control types: hazard sequencer states and register index width.
// Reused by the ID-stage control mux and the forwarding unit.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX/MEM observations in, stall/flush controls out.
// master = pipeline datapath side, slave = hazard sequencer.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W,
    parameter int CNT_W      = 16
);

    logic [REG_ADDR_W-1:0] ifid_rs1_i;
    logic [REG_ADDR_W-1:0] ifid_rs2_i;
    logic                  ifid_rs1_used_i;
    logic                  ifid_rs2_used_i;
    logic [REG_ADDR_W-1:0] idex_rd_i;
    logic                  idex_mem_read_i;
    logic                  branch_taken_i;
    logic                  dmem_req_i;
    logic                  dmem_ready_i;

    logic                  hazard_o;
    logic                  pc_we_o;
    logic                  ifid_we_o;
    logic                  ifid_flush_o;
    logic                  idex_flush_o;
    logic                  pipe_freeze_o;
    logic [CNT_W-1:0]      stall_cnt_o;
    logic [CNT_W-1:0]      flush_cnt_o;

    modport master (
        output ifid_rs1_i, ifid_rs2_i,
        output ifid_rs1_used_i, ifid_rs2_used_i,
        output idex_rd_i, idex_mem_read_i,
        output branch_taken_i,
        output dmem_req_i, dmem_ready_i,
        input  hazard_o, pc_we_o, ifid_we_o,
        input  ifid_flush_o, idex_flush_o,
        input  pipe_freeze_o,
        input  stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  ifid_rs1_i, ifid_rs2_i,
        input  ifid_rs1_used_i, ifid_rs2_used_i,
        input  idex_rd_i, idex_mem_read_i,
        input  branch_taken_i,
        input  dmem_req_i, dmem_ready_i,
        output hazard_o, pc_we_o, ifid_we_o,
        output ifid_flush_o, idex_flush_o,
        output pipe_freeze_o,
        output stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// Load-use detector: does the ID instruction read the rd of a load sitting in EX?
// x0 is hardwired to zero, so a load to x0 never creates a dependency.
module hazard_cmp #(
    parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  mem_read,
    output logic                  lu
);

    logic rd_nz;
    logic hit1;
    logic hit2;

    assign rd_nz = |rd;
    assign hit1  = rs1_used && (rs1 == rd);
    assign hit2  = rs2_used && (rs2 == rd);
    assign lu    = mem_read && rd_nz && (hit1 || hit2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// redirect flushes, data-memory wait freezes and wrap-around event counters.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W,
    parameter int LU_STALL   = 1,
    parameter int CNT_W      = 16
) (
    input logic                   clk_i,
    input logic                   rst_i,
    pipeline_hazard_ctrl_if.slave bus
);

    import pipe_ctrl_pkg::*;

    localparam logic [1:0] LU_REM = 2'(LU_STALL - 1);

    hz_state_t        state_q;
    hz_state_t        state_d;
    logic [1:0]       rem_q;
    logic [1:0]       rem_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic lu;
    logic mw;
    logic in_stall;
    logic go_mw;
    logic go_br;
    logic go_hold;
    logic go_lu;

    logic hazard;
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_flush;
    logic freeze;

    hazard_cmp #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_cmp (
        .rs1      (bus.ifid_rs1_i),
        .rs2      (bus.ifid_rs2_i),
        .rs1_used (bus.ifid_rs1_used_i),
        .rs2_used (bus.ifid_rs2_used_i),
        .rd       (bus.idex_rd_i),
        .mem_read (bus.idex_mem_read_i),
        .lu       (lu)
    );

    assign mw       = bus.dmem_req_i && !bus.dmem_ready_i;
    assign in_stall = (state_q == pipe_ctrl_pkg::LU_STALL);

    // Mutually exclusive decode of the priority chain mw > branch > stall/lu.
    // MEM_WAIT decodes exactly like RUN: while mw it keeps freezing, and on
    // release the same cycle's inputs get the normal RUN treatment.
    assign go_mw   = mw;
    assign go_br   = !mw && bus.branch_taken_i;
    assign go_hold = !mw && !bus.branch_taken_i && in_stall;
    assign go_lu   = !mw && !bus.branch_taken_i && !in_stall && lu;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        hazard     = 1'b0;
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        freeze     = 1'b0;
        unique case (1'b1)
            go_mw: begin
                freeze  = 1'b1;
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                state_d = MEM_WAIT;
            end
            go_br: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                state_d    = RUN;
            end
            go_hold: begin
                hazard  = 1'b1;
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                rem_d   = rem_q - 2'd1;
                state_d = (rem_q == 2'd1) ? RUN : pipe_ctrl_pkg::LU_STALL;
            end
            go_lu: begin
                hazard  = 1'b1;
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                if (LU_STALL > 1) begin
                    state_d = pipe_ctrl_pkg::LU_STALL;
                    rem_d   = LU_REM;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            rem_q       <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (!pc_we) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (ifid_flush) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    // Everything is forced low while reset is held.
    assign bus.hazard_o      = hazard && !rst_i;
    assign bus.pc_we_o       = pc_we && !rst_i;
    assign bus.ifid_we_o     = ifid_we && !rst_i;
    assign bus.ifid_flush_o  = ifid_flush && !rst_i;
    assign bus.idex_flush_o  = idex_flush && !rst_i;
    assign bus.pipe_freeze_o = freeze && !rst_i;
    assign bus.stall_cnt_o   = rst_i ? '0 : stall_cnt_q;
    assign bus.flush_cnt_o   = rst_i ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl with LU_STALL = 1, 2, 3 side by side,
// checked against a bubble-debt reference model.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1 = '0;
    logic [4:0] rs2 = '0;
    logic       u1  = 1'b0;
    logic       u2  = 1'b0;
    logic [4:0] rd  = '0;
    logic       mr  = 1'b0;
    logic       br  = 1'b0;
    logic       req = 1'b0;
    logic       rdy = 1'b0;

    logic [5:0]    obits [3];
    logic [CW-1:0] sc    [3];
    logic [CW-1:0] fc    [3];

    int pend [3];
    int scnt [3];
    int fcnt [3];
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(CW)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].ifid_rs1_i      = rs1;
        assign bus[g].ifid_rs2_i      = rs2;
        assign bus[g].ifid_rs1_used_i = u1;
        assign bus[g].ifid_rs2_used_i = u2;
        assign bus[g].idex_rd_i       = rd;
        assign bus[g].idex_mem_read_i = mr;
        assign bus[g].branch_taken_i  = br;
        assign bus[g].dmem_req_i      = req;
        assign bus[g].dmem_ready_i    = rdy;
        assign obits[g] = {bus[g].hazard_o, bus[g].pc_we_o,
                           bus[g].ifid_we_o, bus[g].ifid_flush_o,
                           bus[g].idex_flush_o, bus[g].pipe_freeze_o};
        assign sc[g] = bus[g].stall_cnt_o;
        assign fc[g] = bus[g].flush_cnt_o;

        pipeline_hazard_ctrl #(
            .REG_ADDR_W (5),
            .LU_STALL   (g + 1),
            .CNT_W      (CW)
        ) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check Mealy outputs, advance model at posedge.
    task automatic step(input logic r,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic e1, input logic e2,
                        input logic [4:0] d, input logic m,
                        input logic b, input logic q, input logic y);
        logic [5:0] exp [3];
        int         npend [3];
        logic       lu;
        logic       mw;
        @(negedge clk);
        rst = r; rs1 = a1; rs2 = a2; u1 = e1; u2 = e2;
        rd = d; mr = m; br = b; req = q; rdy = y;
        #1;
        lu = m && (d != 0) && ((e1 && a1 == d) || (e2 && a2 == d));
        mw = q && !y;
        for (int i = 0; i < 3; i++) begin
            npend[i] = 0;
            if (r)                exp[i] = 6'b000000;
            else if (mw)          exp[i] = 6'b000001;
            else if (b)           exp[i] = 6'b011110;
            else if (pend[i] > 0) begin
                exp[i]   = 6'b100000;
                npend[i] = pend[i] - 1;
            end else if (lu) begin
                exp[i]   = 6'b100000;
                npend[i] = i;
            end else              exp[i] = 6'b011000;
            chk($sformatf("outs_L%0d", i + 1), 32'(obits[i]), 32'(exp[i]));
            chk($sformatf("inv_hz_frz_L%0d", i + 1),
                32'(obits[i][5] & obits[i][0]), 32'd0);
            chk($sformatf("inv_flush_we_L%0d", i + 1),
                32'(obits[i][2] & ~obits[i][3]), 32'd0);
            chk($sformatf("stall_cnt_L%0d", i + 1), 32'(sc[i]),
                r ? 32'd0 : 32'(scnt[i]));
            chk($sformatf("flush_cnt_L%0d", i + 1), 32'(fc[i]),
                r ? 32'd0 : 32'(fcnt[i]));
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                pend[i] = 0;
                scnt[i] = 0;
                fcnt[i] = 0;
            end else begin
                pend[i] = npend[i];
                scnt[i] = (scnt[i] + (exp[i][4] ? 0 : 1)) % (1 << CW);
                fcnt[i] = (fcnt[i] + (exp[i][2] ? 1 : 0)) % (1 << CW);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            pend[i] = 0; scnt[i] = 0; fcnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // load x5 in EX, ID reads rs1=5
        step(0, 5, 0, 1, 0, 5, 1, 0, 0, 0);
        idle(4);
        // x0 load and unused rs2 never hazard
        step(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 5, 0, 0, 5, 1, 0, 0, 0);
        idle(1);
        // redirect together with load-use
        step(0, 5, 0, 1, 0, 5, 1, 1, 0, 0);
        idle(1);
        // three-cycle memory wait released in the ready cycle
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        // reset in the second LU_STALL cycle of the LU_STALL=3 instance
        step(0, 7, 7, 0, 1, 7, 1, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // mw interrupting a stall, then lu on release
        step(0, 3, 0, 1, 0, 3, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 3, 0, 1, 0, 3, 1, 0, 1, 1);
        idle(3);
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), 1'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Detects load-use hazards, branch/jump redirects and multi-cycle data-memory accesses.
- Drives the bubble request into the ID-stage control mux, plus per-stage write enables and flushes.
- Keeps wrap-around stall/flush event counters for performance debug.

Parameters:
- REG_ADDR_W, 5: register index width.
- LU_STALL, 1: load-use bubbles to insert (1 with EX forwarding, 2 without); legal 1..3.
- CNT_W, 16: width of the performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ifid_rs1_i  in  REG_ADDR_W  rs1 of the instruction in ID
- ifid_rs2_i  in  REG_ADDR_W  rs2 of the instruction in ID
- ifid_rs1_used_i  in  1  ID instruction reads rs1
- ifid_rs2_used_i  in  1  ID instruction reads rs2
- idex_rd_i  in  REG_ADDR_W  rd of the instruction in EX
- idex_mem_read_i  in  1  EX instruction is a load
- branch_taken_i  in  1  EX resolved redirect (taken branch/jump)
- dmem_req_i  in  1  MEM-stage access active
- dmem_ready_i  in  1  data memory completes this cycle
- hazard_o  out  1  bubble request to the control mux
- pc_we_o  out  1  PC write enable
- ifid_we_o  out  1  IF/ID write enable
- ifid_flush_o  out  1  clear IF/ID to NOP
- idex_flush_o  out  1  clear ID/EX to NOP
- pipe_freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB
- stall_cnt_o  out  CNT_W  cycles with pc_we_o=0 (excluding reset)
- flush_cnt_o  out  CNT_W  redirect flush events

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- While rst_i is high: state=RUN, counters=0, all outputs 0.
- State machine: RUN, LU_STALL, MEM_WAIT. State and stall counter are registered; outputs are a Mealy function of state plus inputs in the same cycle (0-cycle latency).
- Load-use condition (lu):
  - idex_mem_read_i && idex_rd_i!=0 && ((rs1_used && rs1==rd) || (rs2_used && rs2==rd)).
  - rd=x0 never hazards.
- mw condition: dmem_req_i && !dmem_ready_i.
- Output defaults: pc_we=1, ifid_we=1, all other outputs 0.
- Priority in every state: mw > branch_taken_i > lu.
- RUN:
  - mw: pipe_freeze=1, pc_we=0, ifid_we=0; next state MEM_WAIT.
  - else branch_taken_i: ifid_flush=1, idex_flush=1, pc_we=1; flush_cnt++; stay in RUN. Any lu in the same cycle is ignored.
  - else lu: hazard=1, pc_we=0, ifid_we=0. If LU_STALL>1, go to LU_STALL with remaining=LU_STALL-1; else stay in RUN.
- LU_STALL:
  - hazard=1, pc_we=0, ifid_we=0; decrement remaining; return to RUN when remaining reaches 0.
  - Idex_* inputs are not re-checked here (EX holds a bubble).
  - mw still has priority and goes to MEM_WAIT. The unfinished stall is dropped; the lu check redoes it after return.
  - branch_taken_i (should not occur) aborts the stall: flush as in RUN, next state RUN.
- MEM_WAIT:
  - Freeze (pipe_freeze=1, pc_we=0, ifid_we=0, hazard=0) while mw.
  - The first cycle with dmem_ready_i=1 or dmem_req_i=0 releases the freeze in that same cycle, with RUN decoding applied to that cycle's inputs; next state RUN.
  - No timeout.
- Counters: stall_cnt increments every cycle pc_we_o=0; flush_cnt per flush cycle. Both wrap modulo 2^CNT_W.
- Reset mid-stall or mid-wait: returns to RUN next cycle; counters cleared.
- Invariants:
  - hazard_o and pipe_freeze_o are never both 1.
  - ifid_flush_o=1 implies ifid_we_o=1.

Decomposition:
- Shared package pipe_ctrl_pkg: hz_state_t enum (RUN, LU_STALL, MEM_WAIT) and REG_ADDR_W constant; reused by the control mux and forwarding unit.
- One sub-module hazard_cmp: combinational lu detection (register compare plus x0 guard), reusable by the forwarding unit.

Test Plan:
- Load x5 in EX, ID uses rs1=5, LU_STALL=1 -> one cycle hazard=1, pc_we=0, ifid_we=0; next cycle defaults; stall_cnt=1.
- Same stimulus with LU_STALL=2 -> two consecutive hazard cycles, state RUN→LU_STALL→RUN; stall_cnt=2.
- Load rd=x0 with ID rs1=0 used, or ID rs2=5 with rs2_used=0 -> no hazard; all defaults.
- lu and branch_taken_i asserted together -> ifid_flush=idex_flush=1, pc_we=1, hazard=0; flush_cnt=1.
- dmem_req=1 with ready low for 3 cycles then high -> pipe_freeze=1 for exactly 3 cycles, released in the ready cycle; stall_cnt=3.
- rst_i asserted in the second LU_STALL cycle (LU_STALL=3) -> outputs 0 in the reset cycle; RUN with counters 0 afterwards.
